// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - memory request handshake between control FSM and memory
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I subset main control FSM
module multicycle_control_fsm (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic                      alu_zero,
  multicycle_control_fsm_if.master  mem,
  output logic                      pc_update,
  output logic                      ir_write,
  output logic                      reg_write,
  output logic [1:0]                alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                result_src,
  output logic [1:0]                alu_op_type,
  output logic                      illegal_instr,
  output logic [3:0]                state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t st;

  logic is_lw, is_sw, is_r, is_addi, is_jal, is_br;
  assign is_lw   = (opcode == OP_LOAD);
  assign is_sw   = (opcode == OP_STORE);
  assign is_r    = (opcode == OP_REG);
  assign is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_jal  = (opcode == OP_JAL);
  assign is_br   = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:    if (mem.mem_ready) st <= S_DECODE;
        S_DECODE: begin
          if (is_lw || is_sw) st <= S_MEMADR;
          else if (is_r)      st <= S_EXECR;
          else if (is_addi)   st <= S_EXECI;
          else if (is_jal)    st <= S_JAL;
          else if (is_br)     st <= S_BRANCH;
          else                st <= S_ILLEGAL;
        end
        S_MEMADR:   st <= is_lw ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem.mem_ready) st <= S_MEMWB;
        S_MEMWB:    st <= S_FETCH;
        S_MEMWRITE: if (mem.mem_ready) st <= S_FETCH;
        S_EXECR:    st <= S_ALUWB;
        S_ALUWB:    st <= S_FETCH;
        S_EXECI:    st <= S_ALUWB;
        S_JAL:      st <= S_ALUWB;
        S_BRANCH:   st <= S_FETCH;
        S_ILLEGAL:  st <= S_ILLEGAL;
        default:    st <= S_ILLEGAL;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    pc_update     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.adr_src   = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op_type   = 2'b00;
    illegal_instr = 1'b0;
    case (st)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        // PC+4 is computed and loaded only on the completing fetch cycle
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem.adr_src = 1'b1;
        mem.mem_req = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem.adr_src = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_op_type = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_op_type = 2'b01;
        // funct3[0] distinguishes BNE from BEQ
        pc_update   = alu_zero ^ funct3[0];
      end
      S_ILLEGAL:  illegal_instr = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_update     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       pc_update, ir_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op_type;
  logic [3:0] state;

  multicycle_control_fsm_if mif ();

  multicycle_control_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .alu_zero      (alu_zero),
    .mem           (mif.master),
    .pc_update     (pc_update),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .alu_op_type   (alu_op_type),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [14:0] dut_out;
  assign dut_out = {pc_update, ir_write, reg_write, mif.mem_req, mif.mem_we, mif.adr_src,
                    alu_src_a, alu_src_b, result_src, alu_op_type, illegal_instr};

  logic [4:0] dut_strobes;
  assign dut_strobes = {pc_update, ir_write, reg_write, mif.mem_req, mif.mem_we};

  // Expected outputs per state from the documented output table
  function automatic logic [14:0] model_out(int s, logic rdy, logic z, logic [2:0] f3);
    logic pc, ir, rw, rq, we, ad, il;
    logic [1:0] a, b, rs, op;
    {pc, ir, rw, rq, we, ad, il} = '0;
    {a, b, rs, op} = '0;
    case (s)
      0:  begin rq = 1; if (rdy) begin ir = 1; pc = 1; b = 2'b10; rs = 2'b10; end end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin ad = 1; rq = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin ad = 1; rq = 1; we = 1; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  rw = 1;
      8:  begin a = 2'b10; b = 2'b01; end
      9:  begin a = 2'b01; b = 2'b10; pc = 1; end
      10: begin a = 2'b10; op = 2'b01; pc = z ^ f3[0]; end
      11: il = 1;
      default: ;
    endcase
    return {pc, ir, rw, rq, we, ad, a, b, rs, op, il};
  endfunction

  int seq[$];
  bit rdyq[$];

  // Memory states wait n-1 cycles then see ready; others get random ready noise
  task automatic push(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      seq.push_back(s);
      if (s == 0 || s == 3 || s == 5) rdyq.push_back(i == n - 1);
      else rdyq.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic play();
    for (int i = 0; i < seq.size(); i++) begin
      mif.mem_ready = rdyq[i];
      @(negedge clk);
      check("state", 32'(state), 32'(seq[i]));
      check("outputs", 32'(dut_out), 32'(model_out(seq[i], rdyq[i], alu_zero, funct3)));
      @(posedge clk); #1;
    end
    seq.delete();
    rdyq.delete();
  endtask

  // kind: 0 LW, 1 SW, 2 R, 3 ADDI, 4 JAL, 5 BEQ, 6 BNE
  task automatic run_instr(input int kind, input int wf, input int wm, input logic z);
    funct3   = 3'($urandom);
    alu_zero = z;
    case (kind)
      0: opcode = 7'b0000011;
      1: opcode = 7'b0100011;
      2: opcode = 7'b0110011;
      3: begin opcode = 7'b0010011; funct3 = 3'b000; end
      4: opcode = 7'b1101111;
      5: begin opcode = 7'b1100011; funct3 = 3'b000; end
      default: begin opcode = 7'b1100011; funct3 = 3'b001; end
    endcase
    push(0, wf + 1);
    push(1, 1);
    case (kind)
      0: begin push(2, 1); push(3, wm + 1); push(4, 1); end
      1: begin push(2, 1); push(5, wm + 1); end
      2: begin push(6, 1); push(7, 1); end
      3: begin push(8, 1); push(7, 1); end
      4: begin push(9, 1); push(7, 1); end
      default: push(10, 1);
    endcase
    play();
  endtask

  task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
    push(0, 1);
    push(1, 1);
    push(11, 12);
    play();
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("illegal_rst_flag", 32'(illegal_instr), 32'd0);
    check("illegal_rst_strobes", 32'(dut_strobes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check("illegal_rst_state", 32'(state), 32'd0);
    check("illegal_rst_flag_after", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'd0;
    funct3 = 3'd0;
    alu_zero = 1'b0;
    mif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'(dut_strobes), 32'd0);
    check("reset_illegal", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(3, 0, 0, 1'b0);
    run_instr(0, 2, 1, 1'b0);
    run_instr(5, 0, 0, 1'b1);
    run_instr(5, 0, 0, 1'b0);
    run_instr(6, 0, 0, 1'b1);
    run_instr(6, 0, 0, 1'b0);
    run_instr(2, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);
    for (int i = 0; i < 300; i++)
      run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    run_illegal(7'b0010011, 3'b101);
    run_illegal(7'b0000000, 3'b000);

    // Reset abandons a store that is waiting on memory
    opcode = 7'b0100011;
    funct3 = 3'b010;
    push(0, 1);
    push(1, 1);
    push(2, 1);
    seq.push_back(5); rdyq.push_back(1'b0);
    seq.push_back(5); rdyq.push_back(1'b0);
    play();
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("sw_rst_req_we", 32'({mif.mem_req, mif.mem_we}), 32'd0);
    check("sw_rst_strobes", 32'(dut_strobes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_no_write", 32'({reg_write, pc_update}), 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
